// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic arithmetic unit:
// gate modes, FSM states and the 31-bit LFSR definition.
package sc_pkg;

    localparam int unsigned LFSR_W      = 31;
    localparam int unsigned LFSR_TAP_HI = 30;
    localparam int unsigned LFSR_TAP_LO = 27;

    typedef enum logic [1:0] {
        SC_AND  = 2'b00,
        SC_XNOR = 2'b01,
        SC_MUX  = 2'b10,
        SC_XOR  = 2'b11
    } sc_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } sc_state_e;

    // One Fibonacci step for x^31 + x^28 + 1
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/stochastic_arith_unit_if.sv
// Operand/result bus of the stochastic arithmetic unit.
// master = requester (pin mux side), slave = the arithmetic core.
interface stochastic_arith_unit_if #(
    parameter int unsigned WIDTH = 9
) ();

    logic             start;
    logic [1:0]       mode;
    logic             ser_valid;
    logic             ser_a;
    logic             ser_b;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             overflow;

    modport master (
        output start, mode, ser_valid, ser_a, ser_b,
        input  busy, result, result_valid, overflow
    );

    modport slave (
        input  start, mode, ser_valid, ser_a, ser_b,
        output busy, result, result_valid, overflow
    );

endinterface

// File: rtl/sc_lfsr31.sv
// Free-running 31-bit maximal-length LFSR used as a random number source.
module sc_lfsr31
    import sc_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 31'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/stochastic_arith_unit.sv
// Stochastic-computing core: serial operand load, LFSR-based bitstream
// generation, mode-selected gate and windowed ones-count decode.
module stochastic_arith_unit
    import sc_pkg::*;
#(
    parameter int unsigned       WIDTH    = 9,
    parameter int unsigned       WIN_LOG2 = 17,
    parameter logic [LFSR_W-1:0] SEED_A   = 31'd1,
    parameter logic [LFSR_W-1:0] SEED_B   = 31'd2,
    parameter logic [LFSR_W-1:0] SEED_S   = 31'h5A5A5A5
) (
    input logic                   clk,
    input logic                   rst_n,
    stochastic_arith_unit_if.slave bus
);

    localparam int unsigned CNT_W = WIN_LOG2 + 1;
    localparam int unsigned BIT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] RUN_FILL = CNT_W'(2);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'((1 << WIN_LOG2) + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    logic [LFSR_W-1:0] lfsr_a;
    logic [LFSR_W-1:0] lfsr_b;
    logic [LFSR_W-1:0] lfsr_s;

    sc_lfsr31 #(.SEED(SEED_A)) u_lfsr_a (.clk(clk), .rst_n(rst_n), .q(lfsr_a));
    sc_lfsr31 #(.SEED(SEED_B)) u_lfsr_b (.clk(clk), .rst_n(rst_n), .q(lfsr_b));
    sc_lfsr31 #(.SEED(SEED_S)) u_lfsr_s (.clk(clk), .rst_n(rst_n), .q(lfsr_s));

    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^{lfsr_a[LFSR_W-1:WIDTH], lfsr_b[LFSR_W-1:WIDTH],
                                lfsr_s[LFSR_W-1:WIDTH], lfsr_s[WIDTH-2:0]};

    sc_state_e        state_q, state_d;
    sc_mode_e         mode_q, mode_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             ss_q, ss_d;
    logic             gate_q, gate_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] sb_src;

    // Datapath: SNG comparators (stage 1) and combining gate (stage 2)
    always_comb begin
        sb_src = (mode_q == SC_XOR) ? lfsr_a[WIDTH-1:0] : lfsr_b[WIDTH-1:0];
        sa_d   = (lfsr_a[WIDTH-1:0] < op_a_q);
        sb_d   = (sb_src < op_b_q);
        ss_d   = lfsr_s[WIDTH-1];
        case (mode_q)
            SC_AND:  gate_d = sa_q & sb_q;
            SC_XNOR: gate_d = ~(sa_q ^ sb_q);
            SC_MUX:  gate_d = ss_q ? sb_q : sa_q;
            default: gate_d = sa_q ^ sb_q;
        endcase
    end

    // Control FSM, operand shift-in, window and ones counters, result capture
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        bit_cnt_d      = bit_cnt_q;
        run_cnt_d      = run_cnt_q;
        ones_d         = ones_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        overflow_d     = overflow_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = LOAD;
                    mode_d    = sc_mode_e'(bus.mode);
                    bit_cnt_d = '0;
                end
            end
            LOAD: begin
                if (bus.ser_valid) begin
                    op_a_d    = {op_a_q[WIDTH-2:0], bus.ser_a};
                    op_b_d    = {op_b_q[WIDTH-2:0], bus.ser_b};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = RUN;
                        bit_cnt_d = '0;
                        run_cnt_d = '0;
                        ones_d    = '0;
                    end
                end
            end
            RUN: begin
                run_cnt_d = run_cnt_q + CNT_W'(1);
                // First two RUN cycles only fill the SNG/gate pipeline
                if (run_cnt_q >= RUN_FILL) begin
                    ones_d = ones_q + CNT_W'(gate_q);
                end
                if (run_cnt_q == RUN_LAST) begin
                    state_d        = DONE;
                    overflow_d     = ones_d[WIN_LOG2];
                    result_d       = ones_d[WIN_LOG2] ? '1 : ones_d[WIN_LOG2-1 -: WIDTH];
                    result_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                run_cnt_d = '0;
                ones_d    = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mode_q         <= SC_AND;
            op_a_q         <= '0;
            op_b_q         <= '0;
            bit_cnt_q      <= '0;
            run_cnt_q      <= '0;
            ones_q         <= '0;
            sa_q           <= 1'b0;
            sb_q           <= 1'b0;
            ss_q           <= 1'b0;
            gate_q         <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            bit_cnt_q      <= bit_cnt_d;
            run_cnt_q      <= run_cnt_d;
            ones_q         <= ones_d;
            sa_q           <= sa_d;
            sb_q           <= sb_d;
            ss_q           <= ss_d;
            gate_q         <= gate_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.overflow     = overflow_q;

endmodule
